// File: rtl/calc_seq_dp.sv
// Sequenced calculator datapath: register file + ALU driven by an internal
// IDLE/LOAD_A/LOAD_B/EXEC/READ sequencer. Define CALC_FLAGS_EN for carry/zero outputs.
module calc_seq_dp #(
    parameter int WIDTH  = 3,
    parameter int NREG   = 4,
    parameter int ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  in1,
    input  logic [WIDTH-1:0]  in2,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  out
`ifdef CALC_FLAGS_EN
    ,
    output logic              carry,
    output logic              zero
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        READ   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_XOR  = 3'b000,
        OP_AND  = 3'b001,
        OP_SUB  = 3'b010,
        OP_ADD  = 3'b011,
        OP_OR   = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } op_t;

    state_t             state;
    logic [WIDTH-1:0]   in1_q;
    logic [WIDTH-1:0]   in2_q;
    op_t                op_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [WIDTH-1:0]   rf [NREG];

    logic [WIDTH-1:0]   rf_a;
    logic [WIDTH-1:0]   rf_b;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   rd_dst;

    assign rf_a   = rf[1];
    assign rf_b   = rf[2];
    // R0 is hardwired to zero on read; its storage is never written.
    assign rd_dst = (dst_q == '0) ? '0 : rf[dst_q];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_XOR:  alu_res = rf_a ^ rf_b;
            OP_AND:  alu_res = rf_a & rf_b;
            OP_SUB:  alu_res = rf_a - rf_b;
            OP_ADD:  alu_res = rf_a + rf_b;
            OP_OR:   alu_res = rf_a | rf_b;
            // Logical shifts by an amount >= WIDTH already yield zero.
            OP_SHL:  alu_res = rf_a << rf_b;
            OP_SHR:  alu_res = rf_a >> rf_b;
            OP_PASS: alu_res = rf_a;
            default: alu_res = '0;
        endcase
    end

`ifdef CALC_FLAGS_EN
    logic [WIDTH:0] sum_ext;
    logic           alu_cy;
    logic           cy_q;

    assign sum_ext = {1'b0, rf_a} + {1'b0, rf_b};

    always_comb begin
        alu_cy = 1'b0;
        if (op_q == OP_ADD)
            alu_cy = sum_ext[WIDTH];
        else if (op_q == OP_SUB)
            alu_cy = (rf_a < rf_b);
    end
`endif

    // NOTE: the register file sits inside the async reset, so every entry clears with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            in1_q <= '0;
            in2_q <= '0;
            op_q  <= OP_XOR;
            dst_q <= '0;
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
`ifdef CALC_FLAGS_EN
            cy_q  <= 1'b0;
            carry <= 1'b0;
            zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        in1_q <= in1;
                        in2_q <= in2;
                        op_q  <= op_t'(op);
                        dst_q <= dst;
                        busy  <= 1'b1;
                        state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    rf[1] <= in1_q;
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    rf[2] <= in2_q;
                    state <= EXEC;
                end
                EXEC: begin
                    if (dst_q != '0)
                        rf[dst_q] <= alu_res;
`ifdef CALC_FLAGS_EN
                    // Carry is frozen here: a dst of R1/R2 changes the ALU inputs afterwards.
                    cy_q <= alu_cy;
`endif
                    state <= READ;
                end
                READ: begin
                    out   <= rd_dst;
                    done  <= 1'b1;
                    busy  <= 1'b0;
`ifdef CALC_FLAGS_EN
                    carry <= cy_q;
                    zero  <= (rd_dst == '0);
`endif
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
